// File: rtl/result_bcd_conv_if.sv
//----------------------------------------------------------------------------
// Module      : result_bcd_conv_if
// Description : Start/busy/done handshake and converted-result bus between
//               the calculator controller and the BCD result converter.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface result_bcd_conv_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  start;
    logic [WIDTH-1:0]      value_in;
    logic                  busy;
    logic                  done;
    logic                  valid;
    logic                  negative;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [DIGITS-1:0]     blank_mask;

    modport master (
        output start,
        output value_in,
        input  busy,
        input  done,
        input  valid,
        input  negative,
        input  bcd_out,
        input  blank_mask
    );

    modport slave (
        input  start,
        input  value_in,
        output busy,
        output done,
        output valid,
        output negative,
        output bcd_out,
        output blank_mask
    );
endinterface

`default_nettype wire

// File: rtl/result_bcd_conv.sv
//----------------------------------------------------------------------------
// Module      : result_bcd_conv
// Description : Sequential double-dabble converter from a signed WIDTH-bit
//               result to sign + DIGITS BCD digits, held for the display.
//               Optional macro LEADING_ZERO_BLANK_EN enables blank_mask.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module result_bcd_conv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  wire logic          clk,
    input  wire logic          nRST,
    result_bcd_conv_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sign;
    logic [WIDTH-1:0]    r_mag;
    logic [BCD_W-1:0]    r_scratch;
    logic                r_busy;
    logic                r_done;
    logic                r_valid;
    logic                r_negative;
    logic [BCD_W-1:0]    r_bcd_out;
    logic [DIGITS-1:0]   r_blank_mask;

    logic [WIDTH:0]      w_ext;
    logic [WIDTH-1:0]    w_mag;
    logic [BCD_W-1:0]    w_adj;
    logic [DIGITS-1:0]   w_blank;

    // Negate one bit wider so the most negative input yields its true magnitude.
    assign w_ext = {bus.value_in[WIDTH-1], bus.value_in};
    assign w_mag = bus.value_in[WIDTH-1] ? WIDTH'(-w_ext) : bus.value_in;

    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Units digit is never blanked so a zero result still shows one "0".
    logic w_zero_above;
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above && (r_scratch[4*k +: 4] == 4'd0);
            w_blank[k]   = w_zero_above;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sign       <= 1'b0;
            r_mag        <= '0;
            r_scratch    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_negative   <= 1'b0;
            r_bcd_out    <= '0;
            r_blank_mask <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sign    <= bus.value_in[WIDTH-1];
                        r_mag     <= w_mag;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= {w_adj[BCD_W-2:0], r_mag[WIDTH-1]};
                    r_mag     <= {r_mag[WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_bcd_out    <= r_scratch;
                    r_negative   <= r_sign;
                    r_blank_mask <= w_blank;
                    r_valid      <= 1'b1;
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.valid      = r_valid;
    assign bus.negative   = r_negative;
    assign bus.bcd_out    = r_bcd_out;
    assign bus.blank_mask = r_blank_mask;

endmodule

`default_nettype wire

// File: tb/tb_result_bcd_conv.sv
//----------------------------------------------------------------------------
// Module      : tb_result_bcd_conv
// Description : Self-checking bench for result_bcd_conv against an
//               arithmetic decimal reference model.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_result_bcd_conv;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic clk;
    logic nRST;
    int   n_checks;
    int   n_fail;

    result_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    result_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input logic [WIDTH-1:0] v);
        int s;
        s = int'($signed(v));
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [4*DIGITS-1:0] exp_bcd(input logic [WIDTH-1:0] v);
        logic [4*DIGITS-1:0] r;
        int m;
        m = mag_of(v);
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] exp_blank(input logic [WIDTH-1:0] v);
        logic [DIGITS-1:0] b;
        b = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int p;
            p = 10;
            for (int k = 1; k < DIGITS; k++) begin
                b[k] = (mag_of(v) < p);
                p = p * 10;
            end
        end
`endif
        return b;
    endfunction

    // Called at #1 after an edge; returns with done sampled high (or timeout).
    task automatic run_conv(input logic [WIDTH-1:0] v, output int lat,
                            output int busy_cycles, output bit stable);
        logic [4*DIGITS-1:0] prev;
        prev        = bus.bcd_out;
        bus.start   = 1'b1;
        bus.value_in = v;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.value_in = WIDTH'($urandom);
        lat = -1;
        busy_cycles = 0;
        stable = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (bus.busy) busy_cycles++;
            @(posedge clk); #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.bcd_out !== prev) stable = 1'b0;
        end
    endtask

    task automatic check_result(input string name, input logic [WIDTH-1:0] v, input int lat);
        n_checks++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected 17", name, lat);
        end
        n_checks++;
        if (bus.bcd_out !== exp_bcd(v)) begin
            n_fail++;
            $display("FAIL %s bcd_out: got %h expected %h", name, bus.bcd_out, exp_bcd(v));
        end
        n_checks++;
        if (bus.negative !== v[WIDTH-1]) begin
            n_fail++;
            $display("FAIL %s negative: got %b expected %b", name, bus.negative, v[WIDTH-1]);
        end
        n_checks++;
        if (bus.blank_mask !== exp_blank(v)) begin
            n_fail++;
            $display("FAIL %s blank_mask: got %b expected %b", name, bus.blank_mask, exp_blank(v));
        end
        n_checks++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid/busy at done: got %b/%b expected 1/0", name, bus.valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.busy, bus.done, bus.valid, bus.negative, bus.bcd_out, bus.blank_mask} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs: got busy=%b done=%b valid=%b neg=%b bcd=%h blank=%b expected all 0",
                     bus.busy, bus.done, bus.valid, bus.negative, bus.bcd_out, bus.blank_mask);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        bit st;
        run_conv(16'd12, lat, bc, st);
        check_result("basic12", 16'd12, lat);
        n_checks++;
        if (bc !== 17) begin
            n_fail++;
            $display("FAIL basic12 busy_cycles: got %0d expected 17", bc);
        end
        n_checks++;
        if (st !== 1'b1) begin
            n_fail++;
            $display("FAIL basic12 stable: got %b expected 1", st);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic12 done_pulse: got done=%b valid=%b expected 0/1", bus.done, bus.valid);
        end
    endtask

    task automatic test_corners();
        logic [WIDTH-1:0] tbl [6];
        int lat, bc;
        bit st;
        tbl[0] = 16'h8000;
        tbl[1] = 16'hFFFF;
        tbl[2] = 16'(-36000);
        tbl[3] = 16'd0;
        tbl[4] = 16'(-40);
        tbl[5] = 16'd32767;
        foreach (tbl[i]) begin
            run_conv(tbl[i], lat, bc, st);
            check_result($sformatf("corner%0d", i), tbl[i], lat);
            n_checks++;
            if (st !== 1'b1) begin
                n_fail++;
                $display("FAIL corner%0d stable: got %b expected 1", i, st);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v;
        int lat, bc;
        bit st;
        for (int i = 0; i < 24; i++) begin
            v = WIDTH'($urandom);
            if (i % 4 == 1) v = WIDTH'($urandom_range(0, 99));
            run_conv(v, lat, bc, st);
            check_result($sformatf("rand%0d", i), v, lat);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        bit st;
        run_conv(16'd777, lat, bc, st);
        check_result("b2b_first", 16'd777, lat);
        // Start issued in the done cycle must be accepted immediately.
        run_conv(16'(-9), lat, bc, st);
        check_result("b2b_second", 16'(-9), lat);
        n_checks++;
        if (bc !== 17) begin
            n_fail++;
            $display("FAIL b2b busy_cycles: got %0d expected 17", bc);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, bc, dones;
        bit st, held;
        logic [4*DIGITS-1:0] got;
        run_conv(16'd99, lat, bc, st);
        check_result("ign99", 16'd99, lat);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.value_in = 16'd5;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.value_in = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.value_in = 16'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0; held = 1'b1; got = '0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) begin
                dones++;
                got = bus.bcd_out;
            end else if (dones == 0 && bus.bcd_out !== 20'h00099) begin
                held = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL ignore done_count: got %0d expected 1", dones);
        end
        n_checks++;
        if (got !== 20'h00005) begin
            n_fail++;
            $display("FAIL ignore result: got %h expected 00005", got);
        end
        n_checks++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore hold_prev: got %b expected 1", held);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc, dones;
        bit st;
        bus.start = 1'b1; bus.value_in = 16'd1234;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        nRST = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.valid, bus.negative, bus.bcd_out, bus.blank_mask} !== '0) begin
            n_fail++;
            $display("FAIL abort outputs: got busy=%b done=%b valid=%b bcd=%h expected all 0",
                     bus.busy, bus.done, bus.valid, bus.bcd_out);
        end
        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b1;
        dones = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL abort no_done: got %0d active cycles expected 0", dones);
        end
        run_conv(16'(-4444), lat, bc, st);
        check_result("after_abort", 16'(-4444), lat);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        nRST     = 1'b0;
        bus.start    = 1'b0;
        bus.value_in = '0;
        #2;
        test_reset();
        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_busy_ignore();
        test_random();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
